// File: rtl/cache_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cache_mem_ctrl
//  Purpose  : Memory-side controller between a small fully associative cache
//             and a synchronous RAM. Serves fill reads (from RAM or from the
//             write-back buffer) and absorbs dirty-line write-backs into a
//             small write-back buffer that drains to RAM in the background.
//  Ports    :
//    Clock        in   system clock, all state on posedge
//    Resetn       in   synchronous active-low reset
//    req_valid    in   cache presents a request
//    req_write    in   1 = write-back, 0 = fill read
//    req_addr     in   block address (ADDR_W)
//    req_wdata    in   write-back data (DATA_W)
//    req_ready    out  request accepted on valid & ready edge
//    resp_valid   out  one-cycle pulse, resp_data valid
//    resp_data    out  fill data (DATA_W)
//    ram_address  out  registered RAM address
//    ram_data     out  registered RAM write data
//    ram_wren     out  registered RAM write enable
//    ram_q        in   RAM read data
//    wb_count     out  occupied write-back buffer entries
//    busy         out  controller not idle or buffer not empty
//  Revision : 1.0  initial release
// ============================================================================
module cache_mem_ctrl #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 5,
    parameter int RAM_LAT  = 2,
    parameter int WB_DEPTH = 2
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [2:0]        wb_count,
    output logic              busy
);

    // RAM_LAT is at most 3, so the latency counter needs 2 bits.
    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2
    } state_t;

    state_t             state_q,       state_d;
    logic [CNT_W-1:0]   lat_cnt_q,     lat_cnt_d;
    logic               resp_valid_q,  resp_valid_d;
    logic [DATA_W-1:0]  resp_data_q,   resp_data_d;
    logic [ADDR_W-1:0]  ram_address_q, ram_address_d;
    logic [DATA_W-1:0]  ram_data_q,    ram_data_d;
    logic               ram_wren_q,    ram_wren_d;

    // A buffer hit is answered one cycle after acceptance; this stage holds
    // the forwarded data for that cycle.
    logic               hit_pend_q,    hit_pend_d;
    logic [DATA_W-1:0]  hit_data_q,    hit_data_d;

    // Write-back buffer kept as a shift register: slot 0 is always the head,
    // slots [0 .. wb_count-1] are valid, newer entries sit at higher slots.
    logic [ADDR_W-1:0]  wb_addr_q [WB_DEPTH];
    logic [ADDR_W-1:0]  wb_addr_d [WB_DEPTH];
    logic [DATA_W-1:0]  wb_data_q [WB_DEPTH];
    logic [DATA_W-1:0]  wb_data_d [WB_DEPTH];
    logic [2:0]         wb_count_q,    wb_count_d;

    logic               wb_full;
    logic               rd_accept;
    logic               wr_accept;
    logic               pop;
    logic               coalesce;
    logic               push;
    logic               rd_hit;
    logic [DATA_W-1:0]  rd_hit_data;
    logic [2:0]         tail;
    logic [WB_DEPTH-1:0] entry_valid;
    logic [WB_DEPTH-1:0] rd_match;
    logic [WB_DEPTH-1:0] wr_match;
    logic [WB_DEPTH-1:0] wr_slot;

    // ------------------------------------------------------------------
    // Handshake and buffer control
    // ------------------------------------------------------------------
    assign wb_full   = (wb_count_q >= 3'(WB_DEPTH));
    assign req_ready = req_write ? !wb_full : (state_q == IDLE);

    assign rd_accept = req_valid && !req_write && (state_q == IDLE);
    assign wr_accept = req_valid &&  req_write && !wb_full;

    // Fill reads win over draining; a drain only starts from IDLE.
    assign pop = (state_q == IDLE) && (wb_count_q != 3'd0) && !rd_accept;

    generate
        for (genvar g = 0; g < WB_DEPTH; g++) begin : g_match
            assign entry_valid[g] = (3'(g) < wb_count_q);
            assign rd_match[g]    = entry_valid[g] && (wb_addr_q[g] == req_addr);
            // The head leaving this edge must not absorb a new write; the
            // write becomes a fresh entry so its data is still drained.
            assign wr_match[g]    = rd_match[g] && !(pop && (g == 0));
        end
    endgenerate

    assign coalesce = |wr_match;
    assign push     = wr_accept && !coalesce;
    // When the head pops, every surviving entry moves down one slot.
    assign wr_slot  = pop ? (wr_match >> 1) : wr_match;
    assign tail     = pop ? (wb_count_q - 3'd1) : wb_count_q;

    // Newest matching entry supplies forwarded fill data.
    always_comb begin
        rd_hit      = 1'b0;
        rd_hit_data = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (rd_match[i]) begin
                rd_hit      = 1'b1;
                rd_hit_data = wb_data_q[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < WB_DEPTH; i++) begin
            wb_addr_d[i] = wb_addr_q[i];
            wb_data_d[i] = wb_data_q[i];
        end
        if (pop) begin
            for (int i = 0; i < WB_DEPTH - 1; i++) begin
                wb_addr_d[i] = wb_addr_q[i+1];
                wb_data_d[i] = wb_data_q[i+1];
            end
        end
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (wr_accept && wr_slot[i]) begin
                wb_data_d[i] = req_wdata;
            end
            if (push && (3'(i) == tail)) begin
                wb_addr_d[i] = req_addr;
                wb_data_d[i] = req_wdata;
            end
        end
    end

    assign wb_count_d = wb_count_q - {2'b00, pop} + {2'b00, push};

    // ------------------------------------------------------------------
    // Read FSM, RAM port and response
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        lat_cnt_d     = lat_cnt_q;
        resp_valid_d  = 1'b0;
        resp_data_d   = resp_data_q;
        hit_pend_d    = 1'b0;
        hit_data_d    = hit_data_q;
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        ram_wren_d    = 1'b0;

        if (hit_pend_q) begin
            resp_valid_d = 1'b1;
            resp_data_d  = hit_data_q;
        end

        case (state_q)
            IDLE: begin
                if (rd_accept) begin
                    if (rd_hit) begin
                        hit_pend_d = 1'b1;
                        hit_data_d = rd_hit_data;
                    end else begin
                        ram_address_d = req_addr;
                        lat_cnt_d     = CNT_W'(RAM_LAT - 1);
                        state_d       = RD_WAIT;
                    end
                end else if (pop) begin
                    ram_address_d = wb_addr_q[0];
                    ram_data_d    = wb_data_q[0];
                    ram_wren_d    = 1'b1;
                end
            end
            RD_WAIT: begin
                if (lat_cnt_q == '0) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = ram_q;
                    state_d      = RD_DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q - CNT_W'(1);
                end
            end
            RD_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q       <= IDLE;
            lat_cnt_q     <= '0;
            resp_valid_q  <= 1'b0;
            resp_data_q   <= '0;
            hit_pend_q    <= 1'b0;
            hit_data_q    <= '0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            ram_wren_q    <= 1'b0;
            wb_count_q    <= 3'd0;
            for (int i = 0; i < WB_DEPTH; i++) begin
                wb_addr_q[i] <= '0;
                wb_data_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            lat_cnt_q     <= lat_cnt_d;
            resp_valid_q  <= resp_valid_d;
            resp_data_q   <= resp_data_d;
            hit_pend_q    <= hit_pend_d;
            hit_data_q    <= hit_data_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            ram_wren_q    <= ram_wren_d;
            wb_count_q    <= wb_count_d;
            for (int i = 0; i < WB_DEPTH; i++) begin
                wb_addr_q[i] <= wb_addr_d[i];
                wb_data_q[i] <= wb_data_d[i];
            end
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign ram_address = ram_address_q;
    assign ram_data    = ram_data_q;
    assign ram_wren    = ram_wren_q;
    assign wb_count    = wb_count_q;
    assign busy        = (state_q != IDLE) || (wb_count_q != 3'd0);

endmodule

`default_nettype wire
